led_strip_driver: RTL
=====================

Name: led_strip_driver

Overview:
- Reader end of the LED colour buffer. Runs in the LED driver clock domain.
- For each LED index, in order, it requests the colour from the buffer, waits for `color_valid`, and serializes 24 bits (G,R,B, MSB first) onto a WS2812-style single-wire strand.
- Ends each frame with a latch (reset) low period.
- Frames are started on demand by upstream control.

Parameters:
- NUM_LEDS, 50, number of LEDs on the strand; valid range 1..2**LED_ADDRESS_WIDTH.
- LED_ADDRESS_WIDTH, 10, width of the buffer read address.
- T0H_CYCLES, 40, clk_led cycles high for a 0 bit (0.40 us at 100 MHz).
- T0L_CYCLES, 85, clk_led cycles low for a 0 bit.
- T1H_CYCLES, 80, clk_led cycles high for a 1 bit.
- T1L_CYCLES, 45, clk_led cycles low for a 1 bit.
- LATCH_CYCLES, 6000, clk_led cycles low at end of frame (60 us).

Ports:
- clk_led input 1: LED driver clock.
- rst_led_n input 1: synchronous, active-low reset.
- frame_start input 1: single-cycle pulse; begins a frame when idle.
- led_address output LED_ADDRESS_WIDTH: buffer read address.
- green_in input 8: green byte from the colour buffer.
- red_in input 8: red byte from the colour buffer.
- blue_in input 8: blue byte from the colour buffer.
- color_valid input 1: buffer data is valid for the current led_address.
- strand_out output 1: serial data to the LED strand.
- busy output 1: high from frame acceptance until frame_done.
- frame_done output 1: single-cycle pulse at end of latch period.

Behaviour:
- Reset values, applied while rst_led_n=0 on a clk_led edge:
  - strand_out=0, busy=0, frame_done=0, led_address=0.
  - FSM=IDLE; all counters and the shift register = 0.
- Reset mid-frame aborts immediately, with strand_out=0 from the next cycle. There is no partial-bit completion.
- FSM states: IDLE, FETCH, SEND_HIGH, SEND_LOW, LATCH.
- IDLE:
  - strand_out=0.
  - frame_start=1 → led_index=0, led_address=0, busy=1, go to FETCH.
- FETCH:
  - strand_out=0; led_address=led_index is held stable.
  - Wait for color_valid=1. Color_valid is ignored on the first FETCH cycle after an address change, to cover the buffer's registered read.
  - On acceptance:
    - shift_reg <= {green_in, red_in, blue_in};
    - bit_count=23;
    - go to SEND_HIGH.
  - No timeout: the stall is unbounded.
- SEND_HIGH:
  - strand_out=1 for exactly T1H_CYCLES if shift_reg[23]=1, else T0H_CYCLES.
  - Then go to SEND_LOW.
- SEND_LOW:
  - strand_out=0 for exactly T1L_CYCLES or T0L_CYCLES, matching the current bit.
  - Then one of:
    - bit_count>0 → shift left, decrement bit_count, go to SEND_HIGH.
    - bit_count=0 and led_index<NUM_LEDS-1 → increment led_index, go to FETCH.
    - bit_count=0 and led_index=NUM_LEDS-1 → go to LATCH.
- Inter-LED gap: FETCH time extends the last bit's low period. The minimum gap is 2 cycles; the buffer must answer well under LATCH_CYCLES.
- LATCH:
  - strand_out=0 for LATCH_CYCLES.
  - Then pulse frame_done=1 for one cycle, set busy=0, go to IDLE.
  - busy falls in the same cycle that frame_done is high.
- frame_start while busy=1 is ignored, with no queuing. frame_start in the same cycle as frame_done is also ignored.
- Counters:
  - Phase counter width is $clog2 of the maximum of all timing parameters, plus 1.
  - led_index is LED_ADDRESS_WIDTH bits; it never wraps because it is bounded by NUM_LEDS-1.
- Per-frame output: exactly 24*NUM_LEDS high pulses.
- led_address changes only on FETCH entry.

Optional Feature:
- Macro: LED_STRIP_TEST_PATTERN_EN.
- With the macro defined:
  - Adds input test_pattern (1 bit), sampled on frame acceptance.
  - If the sampled value is 1, the frame uses no buffer data. FETCH lasts exactly 1 cycle and ignores color_valid.
  - Colour is {FF,FF,FF} for led_index==pattern_pos and {00,00,00} otherwise.
  - pattern_pos is an internal counter, reset to 0. It increments on each test-pattern frame_done and wraps from NUM_LEDS-1 to 0.
- Without the macro: the port and counter are absent, and behaviour is exactly as above.

Test Plan:
- Reset with frame_start held high, then release → strand_out=0, busy=0 until the first frame_start after release; led_address=0.
- NUM_LEDS=2; buffer returns G=0xA5,R=0x00,B=0xFF with color_valid 2 cycles after the address → 48 pulses; bits 1,0,1,0,0,1,0,1 have high widths 80,40,80,40,40,80,40,80. Low widths are exact, apart from the FETCH gap.
- color_valid held low for 500 cycles in FETCH for LED 1 → strand_out stays 0 and led_address=1 throughout; transmission resumes with the correct byte order.
- Pulse frame_start mid-frame, and again coincident with frame_done → both ignored; exactly one frame_done occurs; strand low for 6000 cycles before frame_done.
- Assert rst_led_n=0 during SEND_HIGH of LED 0 → strand_out=0 next cycle; busy=0; the next frame_start restarts from LED 0.
- With LED_STRIP_TEST_PATTERN_EN, NUM_LEDS=3, three test-pattern frames → the white LED is at index 0, then 1, then 2, and color_valid is never required.

Source files
------------

// File: rtl/led_strip_driver.sv
// led_strip_driver: reads colours from the LED buffer and serializes them
// onto a WS2812-style strand (G,R,B, MSB first), then holds a latch period.
// Ports: clk_led/rst_led_n (sync, active-low) clock and reset;
//   frame_start pulse begins a frame when idle;
//   led_address/green_in/red_in/blue_in/color_valid form the buffer read side;
//   strand_out is the serial line; busy spans the frame; frame_done pulses at its end.
// Optional: `define LED_STRIP_TEST_PATTERN_EN adds test_pattern (walking white LED).
module led_strip_driver #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int T0H_CYCLES        = 40,
    parameter int T0L_CYCLES        = 85,
    parameter int T1H_CYCLES        = 80,
    parameter int T1L_CYCLES        = 45,
    parameter int LATCH_CYCLES      = 6000
) (
    input  logic                         clk_led,
    input  logic                         rst_led_n,
    input  logic                         frame_start,
    output logic [LED_ADDRESS_WIDTH-1:0] led_address,
    input  logic [7:0]                   green_in,
    input  logic [7:0]                   red_in,
    input  logic [7:0]                   blue_in,
    input  logic                         color_valid,
`ifdef LED_STRIP_TEST_PATTERN_EN
    input  logic                         test_pattern,
`endif
    output logic                         strand_out,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int MAX_A = (T0H_CYCLES > T0L_CYCLES) ? T0H_CYCLES : T0L_CYCLES;
    localparam int MAX_B = (T1H_CYCLES > T1L_CYCLES) ? T1H_CYCLES : T1L_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > LATCH_CYCLES) ? MAX_C : LATCH_CYCLES;
    localparam int PW    = $clog2(MAX_T) + 1;
    localparam int AW    = LED_ADDRESS_WIDTH;

    localparam logic [PW-1:0] T0H_END   = PW'(T0H_CYCLES - 1);
    localparam logic [PW-1:0] T0L_END   = PW'(T0L_CYCLES - 1);
    localparam logic [PW-1:0] T1H_END   = PW'(T1H_CYCLES - 1);
    localparam logic [PW-1:0] T1L_END   = PW'(T1L_CYCLES - 1);
    localparam logic [PW-1:0] LATCH_END = PW'(LATCH_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_HIGH,
        SEND_LOW,
        LATCH
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] ph_cnt;
    logic [4:0]    bit_cnt;
    logic [23:0]   shift_reg;
    logic [AW-1:0] led_index;
    logic          fetch_first;
    logic          strand_q;
    logic          busy_q;
    logic          done_q;

    logic          start, load, shift, next_led, done;
    logic          fetch_ok;
    logic [23:0]   color;
    logic [PW-1:0] hi_end, lo_end;

`ifdef LED_STRIP_TEST_PATTERN_EN
    logic          tp_active;
    logic [AW-1:0] pattern_pos;

    // Pattern frames never wait on the buffer.
    assign fetch_ok = tp_active || (!fetch_first && color_valid);
    assign color    = !tp_active ? {green_in, red_in, blue_in}
                    : (led_index == pattern_pos) ? 24'hFF_FFFF : 24'h00_0000;
`else
    // The first FETCH cycle after an address change sees stale read data.
    assign fetch_ok = !fetch_first && color_valid;
    assign color    = {green_in, red_in, blue_in};
`endif

    assign hi_end = shift_reg[23] ? T1H_END : T0H_END;
    assign lo_end = shift_reg[23] ? T1L_END : T0L_END;

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        next_led = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                // A start coinciding with the previous frame_done is dropped.
                if (frame_start && !done_q) begin
                    start   = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (fetch_ok) begin
                    load    = 1'b1;
                    state_n = SEND_HIGH;
                end
            end
            SEND_HIGH: begin
                if (ph_cnt == hi_end) state_n = SEND_LOW;
            end
            SEND_LOW: begin
                if (ph_cnt == lo_end) begin
                    if (bit_cnt != 5'd0) begin
                        shift   = 1'b1;
                        state_n = SEND_HIGH;
                    end else if (led_index != LAST_IDX) begin
                        next_led = 1'b1;
                        state_n  = FETCH;
                    end else begin
                        state_n = LATCH;
                    end
                end
            end
            LATCH: begin
                if (ph_cnt == LATCH_END) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_led) begin
        if (!rst_led_n) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            led_index   <= '0;
            fetch_first <= 1'b0;
            strand_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LED_STRIP_TEST_PATTERN_EN
            tp_active   <= 1'b0;
            pattern_pos <= '0;
`endif
        end else begin
            state       <= state_n;
            strand_q    <= (state_n == SEND_HIGH);
            done_q      <= done;
            fetch_first <= (state_n == FETCH) && (state != FETCH);

            // Phase counter restarts on every state change.
            if (state_n != state || state == IDLE || state == FETCH)
                ph_cnt <= '0;
            else
                ph_cnt <= ph_cnt + 1'b1;

            if (start)
                busy_q <= 1'b1;
            else if (done)
                busy_q <= 1'b0;

            if (start)
                led_index <= '0;
            else if (next_led)
                led_index <= led_index + 1'b1;

            if (load) begin
                shift_reg <= color;
                bit_cnt   <= 5'd23;
            end else if (shift) begin
                shift_reg <= {shift_reg[22:0], 1'b0};
                bit_cnt   <= bit_cnt - 1'b1;
            end

`ifdef LED_STRIP_TEST_PATTERN_EN
            if (start)
                tp_active <= test_pattern;
            if (done && tp_active)
                pattern_pos <= (pattern_pos == LAST_IDX) ? '0
                             : pattern_pos + 1'b1;
`endif
        end
    end

    assign led_address = led_index;
    assign strand_out  = strand_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule
